moh_apb3_slave: RTL and testbench
=================================

Name: moh_apb3_slave

Overview:
- APB3 completer (slave) holding a small 16-bit register file behind an 8-bit address.
- Sits at the APB bus interface, clocked by the bench clock generator (10-time-unit period).
- Serves as the reference target for the APB3 UVC agent.
- Supports configurable wait states and signals PSLVERR on illegal accesses.

Parameters:
- NUM_REGS, 16: number of read/write registers, at addresses 0..NUM_REGS-1 (legal range 1..255).
- WAIT_STATES, 0: access-phase cycles with ready low before completion (0..15).
- ID_VALUE, 16'hA5C3: constant returned by reads of address 8'hFF.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- psel  input  1  APB select.
- enable  input  1  APB PENABLE; marks the access phase.
- write  input  1  1 = write, 0 = read.
- addr  input  8  register address (word index, not byte address).
- wdata  input  16  write data.
- rdata  output  16  read data; valid only while ready=1 in a read access.
- ready  output  1  PREADY.
- slverr  output  1  PSLVERR; valid only while ready=1.

Behaviour:
- Reset:
  - While reset=1 at a clk edge: all registers clear to 0 and the wait counter clears to 0.
  - Outputs during and after reset are combinational from state: ready=0, slverr=0, rdata=0 until an access phase occurs.
- Phases:
  - Setup = psel=1, enable=0.
  - Access = psel=1, enable=1.
  - enable=1 with psel=0 is ignored: no state change, outputs 0.
- Wait counter wcnt:
  - Increments each clk edge while in access and wcnt<WAIT_STATES.
  - Clears to 0 on the completion edge and whenever psel=0 or enable=0.
- ready = access && (wcnt==WAIT_STATES).
  - WAIT_STATES=0: zero-wait, ready=1 in the first access cycle.
  - WAIT_STATES=N: ready=0 for N access cycles, then 1 for one cycle.
- Completion = ready=1 at a rising clk edge. Write commit happens only on that edge; reads have no side effects.
- Address decode:
  - addr < NUM_REGS: RW register; slverr=0.
  - addr == 8'hFF: read returns ID_VALUE with slverr=0; write sets slverr=1 and does not commit.
  - Any other addr: slverr=1, read rdata=0, write ignored.
- rdata:
  - Combinational from the register at addr when read && ready.
  - 0 otherwise (including during wait states and during writes).
- slverr = ready && illegal access; 0 in all other cycles.
- Back-to-back transfers: a new setup phase may directly follow a completion; wcnt is already 0.
- Reset asserted mid-transfer: transfer aborted, no write commits, wcnt=0. The master must restart from setup.
- Inputs are sampled live at the completion edge; a master changing addr/write/wdata during wait states is a protocol violation. No protection is provided against it.
- Same-register write then read: the read returns the new value (write committed at the prior edge).

Decomposition:
- Package moh_apb3_pkg:
  - ADDR_W=8, DATA_W=16.
  - ID_ADDR=8'hFF, default ID_VALUE.
  - typedef addr_t / data_t.
- Sub-module moh_apb3_regfile:
  - Register array with synchronous clear, one write port (we, waddr, wdata), one combinational read port.
  - Top level holds the phase decode, wait counter, address decode and slverr logic.

Test Plan:
- Reset for 2 cycles, then read addr 0..15 (WAIT_STATES=0) -> each read completes in its first access cycle with rdata=16'h0000, slverr=0.
- Write 16'hBEEF to addr 3, then read addr 3 -> rdata=16'hBEEF, ready=1 in the first access cycle, slverr=0. Addr 2 and 4 still read 0.
- WAIT_STATES=2: write 16'h1234 to addr 5 -> ready low for 2 access cycles, high on the 3rd. A read issued before completion returns the old value; a read after returns 16'h1234.
- Read addr 8'hFF -> rdata=16'hA5C3, slverr=0. Write 16'h0001 to 8'hFF -> slverr=1 on completion; a subsequent read still returns 16'hA5C3.
- Write 16'h5555 to addr 8'h20 (NUM_REGS=16) -> slverr=1. Read 8'h20 -> rdata=0, slverr=1. No register changes.
- WAIT_STATES=3: assert reset during the 2nd wait cycle of a write of 16'hFFFF to addr 1 -> addr 1 reads 0 after reset. The next transfer starts with wcnt=0 and its ready timing is correct.

Source files
------------

// File: rtl/moh_apb3_pkg.sv
// Shared widths, address map constants and bus types for the APB3 register slave.
package moh_apb3_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam addr_t ID_ADDR      = 8'hFF;
  localparam data_t ID_VALUE_DEF = 16'hA5C3;

endpackage

// File: rtl/moh_apb3_regfile.sv
// Register array: synchronous clear, one write port, one combinational read port.
module moh_apb3_regfile
  import moh_apb3_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  addr_t raddr,
  output data_t rdata
);

  localparam int    IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam addr_t NREGS_A = addr_t'(NUM_REGS);

  data_t regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr < NREGS_A)) begin
      regs[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Out-of-range addresses read as zero so a non power-of-two depth never indexes past the array.
  always_comb begin
    rdata = '0;
    if (raddr < NREGS_A) begin
      rdata = regs[raddr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/moh_apb3_slave.sv
// APB3 completer: phase decode, wait-state counter, address decode and PSLVERR around a register file.
module moh_apb3_slave
  import moh_apb3_pkg::*;
#(
  parameter int    NUM_REGS    = 16,
  parameter int    WAIT_STATES = 0,
  parameter data_t ID_VALUE    = ID_VALUE_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  psel,
  input  logic  enable,
  input  logic  write,
  input  addr_t addr,
  input  data_t wdata,
  output data_t rdata,
  output logic  ready,
  output logic  slverr
);

  localparam addr_t      NREGS_A = addr_t'(NUM_REGS);
  localparam logic [3:0] WS      = 4'(WAIT_STATES);

  logic       access;
  logic [3:0] wcnt;
  logic       is_reg;
  logic       is_id;
  logic       illegal;
  logic       we;
  data_t      reg_rdata;

  assign access = psel && enable;
  assign ready  = access && (wcnt == WS);

  // Counter restarts whenever the access phase ends, completes or is aborted.
  always_ff @(posedge clk) begin
    if (reset || !access || ready) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 4'd1;
    end
  end

  assign is_reg  = (addr < NREGS_A);
  assign is_id   = (addr == ID_ADDR);
  assign illegal = write ? !is_reg : !(is_reg || is_id);

  assign slverr = ready && illegal;
  assign we     = ready && write && is_reg;

  always_comb begin
    rdata = '0;
    if (ready && !write) begin
      if (is_reg) begin
        rdata = reg_rdata;
      end else if (is_id) begin
        rdata = ID_VALUE;
      end
    end
  end

  moh_apb3_regfile #(
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .waddr(addr),
    .wdata(wdata),
    .raddr(addr),
    .rdata(reg_rdata)
  );

endmodule

// File: tb/tb_moh_apb3_slave.sv
// Bench for moh_apb3_slave: three instances (0, 2 and 3 wait states) driven by directed transfers.
module tb_moh_apb3_slave;

  localparam int N = 3;

  logic                clk;
  logic [N-1:0]        rst_s;
  logic [N-1:0]        psel_s;
  logic [N-1:0]        en_s;
  logic [N-1:0]        wr_s;
  logic [N-1:0][7:0]   addr_s;
  logic [N-1:0][15:0]  wd_s;
  logic [N-1:0][15:0]  rd_s;
  logic [N-1:0]        rdy_s;
  logic [N-1:0]        err_s;

  int          acc_idx [N];
  logic [15:0] mem     [N][16];
  int          n_chk;
  int          n_pass;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    moh_apb3_slave #(
      .NUM_REGS   (16),
      .WAIT_STATES(ws_of(g)),
      .ID_VALUE   (16'hA5C3)
    ) u_dut (
      .clk   (clk),
      .reset (rst_s[g]),
      .psel  (psel_s[g]),
      .enable(en_s[g]),
      .write (wr_s[g]),
      .addr  (addr_s[g]),
      .wdata (wd_s[g]),
      .rdata (rd_s[g]),
      .ready (rdy_s[g]),
      .slverr(err_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d @%0t: got %h, want %h", nm, k, $time, act, exp);
  endtask

  // Reference model: register contents evolve only on completed legal writes or reset.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst_s[k]) begin
        for (int i = 0; i < 16; i++) mem[k][i] <= 16'h0000;
      end else if (psel_s[k] && en_s[k] && acc_idx[k] == ws_of(k) && wr_s[k] && addr_s[k] < 8'd16) begin
        mem[k][addr_s[k][3:0]] <= wd_s[k];
      end
    end
  end

  // Expected outputs: ready exactly on access cycle number WAIT_STATES, data/error from the address map.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic        er;
      logic        ee;
      logic [15:0] ed;
      er = psel_s[k] && en_s[k] && (acc_idx[k] == ws_of(k));
      if (wr_s[k]) ee = er && !(addr_s[k] < 8'd16);
      else         ee = er && !(addr_s[k] < 8'd16 || addr_s[k] == 8'hFF);
      ed = 16'h0000;
      if (er && !wr_s[k]) begin
        if (addr_s[k] < 8'd16)      ed = mem[k][addr_s[k][3:0]];
        else if (addr_s[k] == 8'hFF) ed = 16'hA5C3;
      end
      chk("ready", k, 16'(rdy_s[k]), 16'(er));
      chk("slverr", k, 16'(err_s[k]), 16'(ee));
      chk("rdata", k, rd_s[k], ed);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int k, input logic w, input logic [7:0] a, input logic [15:0] d,
                      output logic [15:0] r, output logic e);
    psel_s[k] = 1'b1; en_s[k] = 1'b0; wr_s[k] = w; addr_s[k] = a; wd_s[k] = d;
    acc_idx[k] = -1;
    r = 16'h0; e = 1'b0;
    cyc();
    for (int n = 0; n <= ws_of(k); n++) begin
      en_s[k] = 1'b1;
      acc_idx[k] = n;
      if (n == ws_of(k)) begin
        @(negedge clk);
        r = rd_s[k];
        e = err_s[k];
      end
      cyc();
    end
    psel_s[k] = 1'b0; en_s[k] = 1'b0; acc_idx[k] = -1;
  endtask

  task automatic rd_chk(input int k, input logic [7:0] a, input logic [15:0] exp_d, input logic exp_e);
    logic [15:0] r;
    logic        e;
    xfer(k, 1'b0, a, 16'h0, r, e);
    chk("rd_data", k, r, exp_d);
    chk("rd_err", k, 16'(e), 16'(exp_e));
  endtask

  task automatic wr_chk(input int k, input logic [7:0] a, input logic [15:0] d, input logic exp_e);
    logic [15:0] r;
    logic        e;
    xfer(k, 1'b1, a, d, r, e);
    chk("wr_err", k, 16'(e), 16'(exp_e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    for (int k = 0; k < N; k++) acc_idx[k] = -1;
    rst_s = '1; psel_s = '0; en_s = '0; wr_s = '0; addr_s = '0; wd_s = '0;
    cyc();
    cyc();
    rst_s = '0;
    chk("reset_ready", 0, 16'(rdy_s[0]), 16'h0);
    chk("reset_slverr", 0, 16'(err_s[0]), 16'h0);
    chk("reset_rdata", 0, rd_s[0], 16'h0000);

    // Zero-wait instance: cleared map, write/read, ID register, illegal addresses.
    for (int a = 0; a < 16; a++) rd_chk(0, 8'(a), 16'h0000, 1'b0);
    wr_chk(0, 8'd3, 16'hBEEF, 1'b0);
    rd_chk(0, 8'd3, 16'hBEEF, 1'b0);
    rd_chk(0, 8'd2, 16'h0000, 1'b0);
    rd_chk(0, 8'd4, 16'h0000, 1'b0);
    psel_s[0] = 1'b0; en_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 8'd3; wd_s[0] = 16'h1111;
    cyc();
    en_s[0] = 1'b0; wr_s[0] = 1'b0;
    rd_chk(0, 8'd3, 16'hBEEF, 1'b0);
    rd_chk(0, 8'hFF, 16'hA5C3, 1'b0);
    wr_chk(0, 8'hFF, 16'h0001, 1'b1);
    rd_chk(0, 8'hFF, 16'hA5C3, 1'b0);
    wr_chk(0, 8'h20, 16'h5555, 1'b1);
    rd_chk(0, 8'h20, 16'h0000, 1'b1);
    rd_chk(0, 8'd0, 16'h0000, 1'b0);
    rd_chk(0, 8'd3, 16'hBEEF, 1'b0);

    // Two wait states.
    rd_chk(1, 8'd5, 16'h0000, 1'b0);
    wr_chk(1, 8'd5, 16'h1234, 1'b0);
    rd_chk(1, 8'd5, 16'h1234, 1'b0);
    wr_chk(1, 8'h10, 16'h4242, 1'b1);
    rd_chk(1, 8'hFF, 16'hA5C3, 1'b0);

    // Three wait states: reset arrives on the second wait cycle of a write.
    wr_chk(2, 8'd1, 16'h00AA, 1'b0);
    rd_chk(2, 8'd1, 16'h00AA, 1'b0);
    psel_s[2] = 1'b1; en_s[2] = 1'b0; wr_s[2] = 1'b1; addr_s[2] = 8'd1; wd_s[2] = 16'hFFFF;
    acc_idx[2] = -1;
    cyc();
    en_s[2] = 1'b1; acc_idx[2] = 0;
    cyc();
    acc_idx[2] = 1; rst_s[2] = 1'b1;
    cyc();
    psel_s[2] = 1'b0; en_s[2] = 1'b0; acc_idx[2] = -1;
    cyc();
    rst_s[2] = 1'b0;
    rd_chk(2, 8'd1, 16'h0000, 1'b0);
    wr_chk(2, 8'd2, 16'h7777, 1'b0);
    rd_chk(2, 8'd2, 16'h7777, 1'b0);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
